// File: rtl/spi_mem_ctrl_if.sv
// Bus bundle between the CPU fetch/data ports, spi_mem_ctrl and spi_master.
// The slave modport is the controller's view. The master modport is the
// environment's view: the CPU ports plus the spi_master side.
interface spi_mem_ctrl_if;
  // CPU instruction-fetch port
  logic        i_req;
  logic [24:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        i_err;

  // CPU data port
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [24:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_err;

  // spi_master control and data
  logic        spi_start;
  logic        spi_stop;
  logic        spi_write_enable;
  logic        spi_is_instr;
  logic        spi_use_flash_chip;
  logic [23:0] spi_addr;
  logic [5:0]  spi_data_len;
  logic [31:0] spi_data_in;
  logic [31:0] spi_data_out;
  logic        spi_done;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
           spi_data_out, spi_done,
    output i_rdata, i_ready, i_err, d_rdata, d_ready, d_err,
           spi_start, spi_stop, spi_write_enable, spi_is_instr,
           spi_use_flash_chip, spi_addr, spi_data_len, spi_data_in
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
           spi_data_out, spi_done,
    input  i_rdata, i_ready, i_err, d_rdata, d_ready, d_err,
           spi_start, spi_stop, spi_write_enable, spi_is_instr,
           spi_use_flash_chip, spi_addr, spi_data_len, spi_data_in
  );
endinterface

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: arbitrates the CPU fetch and data ports onto one spi_master.
// Data requests win over fetches. Bus data is little-endian. The SPI stream
// is MSB-first, so byte 0 of the bus travels first on the wire. A watchdog
// aborts a transfer whose spi_done never arrives.
module spi_mem_ctrl #(
  parameter int RAM_SEL_BIT    = 24,
  parameter int TIMEOUT_CYCLES = 8191
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mem_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_STOP,
    S_RESP
  } state_e;

  // Puts bus byte 0 in the top byte so that it is shifted out first.
  function automatic logic [31:0] pack_store(input logic [31:0] w, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      2'd0:    r = {w[7:0], 24'b0};
      2'd1:    r = {w[7:0], w[15:8], 16'b0};
      default: r = {w[7:0], w[15:8], w[23:16], w[31:24]};
    endcase
    return r;
  endfunction

  // Received bytes sit right-aligned in spi_data_out, oldest byte highest.
  function automatic logic [31:0] unpack_load(input logic [31:0] s, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      2'd0:    r = {24'b0, s[7:0]};
      2'd1:    r = {16'b0, s[7:0], s[15:8]};
      default: r = {s[7:0], s[15:8], s[23:16], s[31:24]};
    endcase
    return r;
  endfunction

  function automatic logic [5:0] len_for(input logic [1:0] size);
    logic [5:0] r;
    case (size)
      2'd0:    r = 6'd8;
      2'd1:    r = 6'd16;
      default: r = 6'd32;
    endcase
    return r;
  endfunction

  // Sequencer state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_q, fetch_d;   // 1 = serving the fetch port
  logic [1:0]       size_q, size_d;
  logic             err_q, err_d;
  logic [31:0]      data_q, data_d;     // response word, already converted

  // Fields presented to spi_master, which samples them live
  logic             wen_q, wen_d;
  logic             instr_q, instr_d;
  logic             flash_q, flash_d;
  logic [23:0]      addr_q, addr_d;
  logic [5:0]       len_q, len_d;
  logic [31:0]      din_q, din_d;

  // Per-port read data, held until that port's next response
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic             d_to_flash;
  assign d_to_flash = ~bus.d_addr[RAM_SEL_BIT];

  // Next-state and next-field logic for the request sequencer
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can leave
    // one unassigned and infer a latch; blocking '=' is right in always_comb.
    state_d   = state_q;
    cnt_d     = cnt_q;
    fetch_d   = fetch_q;
    size_d    = size_q;
    err_d     = err_q;
    data_d    = data_q;
    wen_d     = wen_q;
    instr_d   = instr_q;
    flash_d   = flash_q;
    addr_d    = addr_q;
    len_d     = len_q;
    din_d     = din_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.d_req) begin
          fetch_d = 1'b0;
          size_d  = bus.d_size;
          err_d   = 1'b0;
          data_d  = '0;
          wen_d   = bus.d_we;
          instr_d = 1'b0;
          flash_d = d_to_flash;
          addr_d  = bus.d_addr[23:0];
          len_d   = len_for(bus.d_size);
          din_d   = bus.d_we ? pack_store(bus.d_wdata, bus.d_size) : '0;
          // Flash is read-only: refuse the store without touching the bus.
          if (bus.d_we && d_to_flash) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
        end else if (bus.i_req) begin
          fetch_d = 1'b1;
          size_d  = 2'd2;
          err_d   = 1'b0;
          data_d  = '0;
          wen_d   = 1'b0;
          instr_d = 1'b1;
          flash_d = ~bus.i_addr[RAM_SEL_BIT];
          addr_d  = bus.i_addr[23:0];
          len_d   = 6'd32;
          din_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A completion in the final watchdog cycle still counts as success.
        if (bus.spi_done) begin
          if (fetch_q) begin
            data_d  = unpack_load(bus.spi_data_out, 2'd2);
            state_d = S_STOP;
          end else begin
            if (!wen_q) begin
              data_d = unpack_load(bus.spi_data_out, size_q);
            end
            state_d = S_RESP;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Publish the response word as RESP is entered so it is valid with ready.
    if (state_d == S_RESP) begin
      if (fetch_d) begin
        i_rdata_d = data_d;
      end else begin
        d_rdata_d = data_d;
      end
    end
  end

  // State and field registers
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; spi_master shares rst_n, so a reset here
    // abandons any transfer on both sides in the same cycle.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      fetch_q   <= 1'b0;
      size_q    <= 2'd0;
      err_q     <= 1'b0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      instr_q   <= 1'b0;
      flash_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      din_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fetch_q   <= fetch_d;
      size_q    <= size_d;
      err_q     <= err_d;
      data_q    <= data_d;
      wen_q     <= wen_d;
      instr_q   <= instr_d;
      flash_q   <= flash_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      din_q     <= din_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Strobes decode straight from the registered state, so they are glitch-free
  // one-cycle pulses and START/STOP can never overlap.
  assign bus.spi_start          = (state_q == S_START);
  assign bus.spi_stop           = (state_q == S_STOP);
  assign bus.spi_write_enable   = wen_q;
  assign bus.spi_is_instr       = instr_q;
  assign bus.spi_use_flash_chip = flash_q;
  assign bus.spi_addr           = addr_q;
  assign bus.spi_data_len       = len_q;
  assign bus.spi_data_in        = din_q;

  assign bus.i_ready = (state_q == S_RESP) &&  fetch_q;
  assign bus.d_ready = (state_q == S_RESP) && !fetch_q;
  assign bus.i_err   = bus.i_ready && err_q;
  assign bus.d_err   = bus.d_ready && err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Testbench for spi_mem_ctrl: table vectors, randomized transactions against a
// byte-level reference model, and hand-written priority/timeout/reset sequences.
// The bench plays both the CPU and spi_master.
module tb_spi_mem_ctrl;

  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_ctrl_if bus();

  spi_mem_ctrl #(.RAM_SEL_BIT(24), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          fetch;
    bit          we;
    logic [1:0]  size;
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdo;       // what spi_master returns
    int          delay;     // WAIT cycles before spi_done, -1 = never
    bit          exp_spi;   // an SPI access is expected
    logic [5:0]  exp_len;
    logic [31:0] exp_din;
    bit          exp_flash;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    int          start_cyc, done_cyc, stop_cyc, ready_cyc;
    int          start_cnt, stop_cnt, unstable, wrong_port, timed_out;
    logic [5:0]  len;
    logic [31:0] din;
    logic [23:0] addr;
    logic        flash, instr, wen;
    logic [31:0] rdata;
    logic        err;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
  endfunction

  // Bus byte k goes out k-th on the wire; the first byte lands in bits 31:24.
  function automatic logic [31:0] model_pack(input logic [31:0] w, input int n);
    logic [31:0] r = 0;
    for (int k = 0; k < n; k++) r |= ((w >> (8 * k)) & 32'hFF) << (24 - 8 * k);
    return r;
  endfunction

  // The k-th received byte of n sits at bits 8*(n-1-k); it becomes bus byte k.
  function automatic logic [31:0] model_unpack(input logic [31:0] s, input int n);
    logic [31:0] r = 0;
    for (int k = 0; k < n; k++) r |= ((s >> (8 * (n - 1 - k))) & 32'hFF) << (8 * k);
    return r;
  endfunction

  function automatic vec_t model(input bit fetch, input bit we, input logic [1:0] size,
                                 input logic [24:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] sdo, input int delay);
    vec_t v;
    int   n = fetch ? 4 : nbytes(size);
    v.fetch = fetch; v.we = we; v.size = size; v.addr = addr;
    v.wdata = wdata; v.sdo = sdo; v.delay = delay;
    v.exp_flash = (addr[24] == 1'b0);
    v.exp_spi   = fetch || !(we && v.exp_flash);
    v.exp_len   = 6'(8 * n);
    v.exp_din   = (!fetch && we) ? model_pack(wdata, n) : 32'h0;
    v.exp_rdata = model_unpack(sdo, n);
    v.exp_err   = !v.exp_spi;
    return v;
  endfunction

  // ---------------- transaction driver / spi_master responder ----------------
  task automatic run_txn(input vec_t v, output obs_t o);
    o = '{default: 0};
    o.start_cyc = -1; o.done_cyc = -1; o.stop_cyc = -1; o.ready_cyc = -1;
    bus.spi_data_out = 32'h0;
    if (v.fetch) begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end else begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_size = v.size;
      bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      bus.spi_done = 1'b0;
      if (bus.spi_start) begin
        o.start_cnt++;
        if (o.start_cyc < 0) begin
          o.start_cyc = cyc;
          o.len = bus.spi_data_len; o.din = bus.spi_data_in; o.addr = bus.spi_addr;
          o.flash = bus.spi_use_flash_chip; o.instr = bus.spi_is_instr;
          o.wen = bus.spi_write_enable;
        end
      end
      if (o.start_cyc >= 0 &&
          (o.len !== bus.spi_data_len || o.din !== bus.spi_data_in ||
           o.addr !== bus.spi_addr || o.flash !== bus.spi_use_flash_chip ||
           o.instr !== bus.spi_is_instr || o.wen !== bus.spi_write_enable ||
           (bus.spi_start && bus.spi_stop)))
        o.unstable++;
      if (bus.spi_stop) begin
        o.stop_cnt++; o.stop_cyc = cyc;
      end
      if (v.delay >= 0 && o.start_cyc >= 0 && cyc == o.start_cyc + 1 + v.delay) begin
        bus.spi_done = 1'b1; bus.spi_data_out = v.sdo; o.done_cyc = cyc;
      end
      if (v.fetch ? bus.d_ready : bus.i_ready) o.wrong_port++;
      if (v.fetch ? bus.i_ready : bus.d_ready) begin
        o.ready_cyc = cyc;
        o.rdata = v.fetch ? bus.i_rdata : bus.d_rdata;
        o.err   = v.fetch ? bus.i_err : bus.d_err;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        break;
      end
    end
    if (o.ready_cyc < 0) o.timed_out = 1;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.spi_done = 1'b0;
    tick();  // RESP -> IDLE
  endtask

  task automatic check_txn(input string tag, input vec_t v, input obs_t o);
    check({tag, ".no_hang"}, o.timed_out, 0);
    check({tag, ".wrong_port"}, o.wrong_port, 0);
    if (v.exp_spi) begin
      check({tag, ".starts"}, o.start_cnt, 1);
      check({tag, ".start_lat"}, o.start_cyc, 1);
      check({tag, ".len"}, o.len, v.exp_len);
      check({tag, ".din"}, o.din, v.exp_din);
      check({tag, ".addr"}, o.addr, v.addr[23:0]);
      check({tag, ".flash"}, o.flash, v.exp_flash);
      check({tag, ".instr"}, o.instr, v.fetch);
      check({tag, ".wen"}, o.wen, v.we && !v.fetch);
      check({tag, ".stable"}, o.unstable, 0);
      if (v.fetch) begin
        check({tag, ".stops"}, o.stop_cnt, 1);
        check({tag, ".stop_lat"}, o.stop_cyc, o.done_cyc + 1);
        check({tag, ".ready_lat"}, o.ready_cyc, o.done_cyc + 2);
      end else begin
        check({tag, ".stops"}, o.stop_cnt, 0);
        check({tag, ".ready_lat"}, o.ready_cyc, o.done_cyc + 1);
      end
    end else begin
      check({tag, ".starts"}, o.start_cnt, 0);
      check({tag, ".stops"}, o.stop_cnt, 0);
      check({tag, ".ready_lat"}, (o.ready_cyc >= 1 && o.ready_cyc <= 2), 1);
    end
    if (v.fetch || !v.we) check({tag, ".rdata"}, o.rdata, v.exp_rdata);
    check({tag, ".err"}, o.err, v.exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ctrl"}, {bus.spi_start, bus.spi_stop, bus.spi_write_enable, bus.spi_is_instr,
                           bus.spi_use_flash_chip, bus.i_ready, bus.d_ready, bus.i_err, bus.d_err}, 0);
    check({tag, ".addr"}, bus.spi_addr, 0);
    check({tag, ".len"}, bus.spi_data_len, 0);
    check({tag, ".din"}, bus.spi_data_in, 0);
    check({tag, ".i_rdata"}, bus.i_rdata, 0);
    check({tag, ".d_rdata"}, bus.d_rdata, 0);
  endtask

  vec_t vecs[10];

  initial begin
    obs_t o;
    vec_t v;

    // fetch, we, size, addr, wdata, sdo, delay, exp_spi, len, din, flash, rdata, err
    vecs[0] = '{0, 0, 2'd2, 25'h1000100, 32'h0,        32'h11223344, 1, 1, 6'd32, 32'h0,        0, 32'h44332211, 0};
    vecs[1] = '{0, 1, 2'd0, 25'h1000003, 32'h000000A5, 32'h0,        0, 1, 6'd8,  32'hA5000000, 0, 32'h0,        0};
    vecs[2] = '{1, 0, 2'd0, 25'h0000200, 32'h0,        32'h01450000, 2, 1, 6'd32, 32'h0,        1, 32'h00004501, 0};
    vecs[3] = '{0, 1, 2'd2, 25'h0000010, 32'h12345678, 32'h0,        0, 0, 6'd32, 32'h0,        1, 32'h0,        1};
    vecs[4] = '{0, 0, 2'd1, 25'h1ABCDEF, 32'h0,        32'h0000BEEF, 0, 1, 6'd16, 32'h0,        0, 32'h0000EFBE, 0};
    vecs[5] = '{0, 1, 2'd1, 25'h1000002, 32'hCAFE1234, 32'h0,        4, 1, 6'd16, 32'h34120000, 0, 32'h0,        0};
    vecs[6] = '{0, 1, 2'd3, 25'h1FFFFFF, 32'h89ABCDEF, 32'h0,        1, 1, 6'd32, 32'hEFCDAB89, 0, 32'h0,        0};
    vecs[7] = '{0, 0, 2'd0, 25'h0123457, 32'h0,        32'hFFFFFF5A, 0, 1, 6'd8,  32'h0,        1, 32'h0000005A, 0};
    vecs[8] = '{0, 0, 2'd2, 25'h0ABCDE0, 32'h0,        32'hDEADBEEF, 3, 1, 6'd32, 32'h0,        1, 32'hEFBEADDE, 0};
    vecs[9] = '{1, 0, 2'd0, 25'h1000004, 32'h0,        32'h13579BDF, 0, 1, 6'd32, 32'h0,        0, 32'hDF9B5713, 0};

    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_size = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.spi_data_out = 0; bus.spi_done = 0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], o);
      check_txn($sformatf("vec%0d", i), vecs[i], o);
    end

    // Randomized transactions against the model
    for (int i = 0; i < 60; i++) begin
      v = model($urandom_range(0, 2) == 0, 1'($urandom), 2'($urandom), 25'($urandom),
                $urandom, $urandom, int'($urandom_range(0, 6)));
      run_txn(v, o);
      check_txn($sformatf("rnd%0d", i), v, o);
    end

    // Simultaneous requests: data first, fetch starts >= 2 cycles after d_ready
    begin
      int starts = 0, last_start = -1, first_instr = -1;
      int d_rdy = -1, f_start = -1, f_rdy = -1;
      bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'd2; bus.d_addr = 25'h1000040;
      bus.i_req = 1; bus.i_addr = 25'h0000080;
      for (int cyc = 1; cyc <= 200; cyc++) begin
        tick();
        bus.spi_done = 0;
        if (bus.spi_start) begin
          starts++;
          if (starts == 1) first_instr = int'(bus.spi_is_instr);
          else f_start = cyc;
          last_start = cyc;
        end
        if (last_start >= 0 && cyc == last_start + 2) begin
          bus.spi_done = 1;
          bus.spi_data_out = (starts == 1) ? 32'hA1B2C3D4 : 32'h55667788;
        end
        if (bus.d_ready) begin
          d_rdy = cyc; bus.d_req = 0;
          check("prio.d_rdata", bus.d_rdata, 32'hD4C3B2A1);
        end
        if (bus.i_ready) begin
          f_rdy = cyc; bus.i_req = 0;
          check("prio.i_rdata", bus.i_rdata, 32'h88776655);
          break;
        end
      end
      bus.i_req = 0; bus.d_req = 0; bus.spi_done = 0;
      tick();
      check("prio.first_is_data", first_instr, 0);
      check("prio.starts", starts, 2);
      check("prio.gap", (d_rdy > 0 && f_start - d_rdy >= 2), 1);
      check("prio.fetch_done", (f_rdy > 0), 1);
    end

    // Watchdog on a data load, then on a fetch, each followed by a normal access
    v = model(0, 0, 2'd2, 25'h1000200, 32'h0, 32'hCAFEF00D, -1);
    run_txn(v, o);
    check("tmo_d.no_hang", o.timed_out, 0);
    check("tmo_d.stops", o.stop_cnt, 1);
    check("tmo_d.wait_cycles", o.stop_cyc - o.start_cyc - 1, TMO);
    check("tmo_d.ready_lat", o.ready_cyc, o.stop_cyc + 1);
    check("tmo_d.err", o.err, 1);
    check("tmo_d.rdata", o.rdata, 0);
    v = model(0, 0, 2'd2, 25'h1000204, 32'h0, 32'h0A0B0C0D, 2);
    run_txn(v, o);
    check_txn("after_tmo_d", v, o);

    v = model(1, 0, 2'd2, 25'h0000300, 32'h0, 32'h12121212, -1);
    run_txn(v, o);
    check("tmo_i.no_hang", o.timed_out, 0);
    check("tmo_i.stops", o.stop_cnt, 1);
    check("tmo_i.wait_cycles", o.stop_cyc - o.start_cyc - 1, TMO);
    check("tmo_i.err", o.err, 1);
    check("tmo_i.rdata", o.rdata, 0);
    v = model(1, 0, 2'd2, 25'h0000304, 32'h0, 32'h76543210, 1);
    run_txn(v, o);
    check_txn("after_tmo_i", v, o);

    // Reset in the middle of a fetch abandons it and clears every output
    bus.i_req = 1; bus.i_addr = 25'h1000300;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (bus.spi_start) break;
    end
    tick();
    rst_n = 1'b0; bus.i_req = 0;
    tick(); tick();
    check_all_zero("midreset");
    rst_n = 1'b1;
    tick();
    v = model(0, 0, 2'd1, 25'h1000310, 32'h0, 32'h00003C4D, 0);
    run_txn(v, o);
    check_txn("after_reset", v, o);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
